mips_data_mem_arbiter: RTL and testbench
========================================

Name: mips_data_mem_arbiter

Overview:
Two-master arbiter and sequencer for the single-port Harvard data memory. Shares the memory between the CPU data port and a debug/loader port used by benches to preload or inspect memory. Fixed CPU priority, with a starvation counter that guarantees the debug port forward progress. Sits between mips_cpu_harvard's data interface and mips_cpu_data_memory; memory read data is valid one cycle after the address is presented.

Parameters:
MAX_WAIT, 8, cycles the debug port may wait with a pending request before it gets priority at the next arbitration (1..255)
ADDR_W, 32, address width on all ports

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-low reset
cpu_address  in  ADDR_W  CPU data address
cpu_read  in  1  CPU read request, held until cpu_waitrequest low
cpu_write  in  1  CPU write request, held until cpu_waitrequest low
cpu_writedata  in  32  CPU write data
cpu_readdata  out  32  CPU read data, valid when read completes
cpu_waitrequest  out  1  high = CPU access not complete
dbg_address  in  ADDR_W  debug address
dbg_read  in  1  debug read request
dbg_write  in  1  debug write request
dbg_writedata  in  32  debug write data
dbg_readdata  out  32  debug read data
dbg_waitrequest  out  1  high = debug access not complete
mem_address  out  ADDR_W  to data memory
mem_read  out  1  to data memory
mem_write  out  1  to data memory
mem_writedata  out  32  to data memory
mem_readdata  in  32  from data memory, valid cycle after mem_read
grant_dbg  out  1  current/last grant owner: 0 = CPU, 1 = debug

Behaviour:
- States: IDLE, CPU_RD, DBG_RD (2-bit encoded).
- Reset (async, reset == 0): state = IDLE, starvation counter = 0, grant_dbg = 0. Outputs while in reset: mem_read = mem_write = 0, cpu_waitrequest = dbg_waitrequest = 1, readdata outputs 0.
- IDLE arbitration, combinational on the current request inputs:
  - Debug wins if dbg request is pending and counter == MAX_WAIT, or if only debug requests.
  - Otherwise the CPU wins if it requests.
  - No request: mem_read = mem_write = 0, both waitrequests high.
- Winner is write: mem_address, mem_writedata and mem_write = 1 are driven from the winner this cycle. The winner's waitrequest goes low this cycle (single-cycle write). State stays IDLE.
- Winner is read: mem_address and mem_read = 1 are driven this cycle. Winner's waitrequest stays high. Next state is CPU_RD or DBG_RD.
- CPU_RD / DBG_RD:
  - mem_read = 0, mem_write = 0.
  - The owner's readdata = mem_readdata and the owner's waitrequest goes low.
  - Next state is IDLE, so there is one idle arbitration cycle between consecutive reads.
- Non-owner waitrequest is always high. Non-owner readdata is 0.
- A requester asserting read and write together is treated as a write; the read is ignored.
- grant_dbg is registered and updates at the edge that ends each granted access.
- Starvation counter:
  - Increments, saturating at MAX_WAIT, on each cycle with a debug request and no debug grant.
  - Clears to 0 on the cycle a debug access is granted.
- Requests must stay stable while waitrequest is high. Dropping a read mid-access still completes the memory read; the data is discarded.
- Reset asserted mid-read aborts the access: state returns to IDLE and no completion is signalled.

Optional Feature:
ARB_PERF_EN:
- Defined: adds output cpu_stall_cycles [31:0]. It is a saturating counter of cycles where the CPU has a request pending, cpu_waitrequest is high and the debug port owns or wins the memory. Cleared by reset.
- Undefined: the port and counter are absent and behaviour is otherwise identical.

Test Plan:
- CPU write 0x00000010 <= 0xDEADBEEF, no debug -> cpu_waitrequest low same cycle, mem_write = 1 for one cycle. Then CPU read 0x10 -> waitrequest high 1 cycle, low next with cpu_readdata = 0xDEADBEEF.
- Debug write 0x20 <= 0x12345678 while the CPU is idle -> dbg_waitrequest low same cycle, grant_dbg = 1 after the edge. CPU read 0x20 -> 0x12345678.
- CPU issues back-to-back reads for 20 cycles while debug holds a read of 0x10 -> debug granted at the arbitration following counter = 8 (MAX_WAIT default), gets 0xDEADBEEF, then the counter is 0.
- Same cycle: CPU write 0x30 <= 1 and debug write 0x30 <= 2, counter 0 -> CPU first, debug next cycle; final mem[0x30] = 2.
- Assert reset low during CPU_RD -> immediately mem_read = 0, both waitrequests high. After release, state is IDLE and a fresh CPU read of 0x10 returns 0xDEADBEEF.
- With ARB_PERF_EN defined, repeat the third scenario -> cpu_stall_cycles increments for each cycle the CPU is blocked by the debug grant, and equals 0 after reset.

Source files
------------

// File: rtl/mips_data_mem_arbiter.sv
// Two-master arbiter for the single-port data memory: CPU has priority,
// a starvation counter guarantees debug forward progress. Macro: ARB_PERF_EN.
module mips_data_mem_arbiter #(
    parameter int MAX_WAIT = 8,
    parameter int ADDR_W   = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] cpu_address,
    input  logic              cpu_read,
    input  logic              cpu_write,
    input  logic [31:0]       cpu_writedata,
    output logic [31:0]       cpu_readdata,
    output logic              cpu_waitrequest,
    input  logic [ADDR_W-1:0] dbg_address,
    input  logic              dbg_read,
    input  logic              dbg_write,
    input  logic [31:0]       dbg_writedata,
    output logic [31:0]       dbg_readdata,
    output logic              dbg_waitrequest,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_read,
    output logic              mem_write,
    output logic [31:0]       mem_writedata,
    input  logic [31:0]       mem_readdata,
    output logic              grant_dbg
`ifdef ARB_PERF_EN
    ,
    output logic [31:0]       cpu_stall_cycles
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CPU_RD = 2'd1,
        DBG_RD = 2'd2
    } state_t;

    localparam logic [7:0] MAX_C = 8'(MAX_WAIT);

    state_t     r_state;
    state_t     w_next;
    logic [7:0] r_cnt;
    logic       r_grant_dbg;

    logic w_cpu_req;
    logic w_dbg_req;
    logic w_dbg_win;
    logic w_cpu_win;

    assign w_cpu_req = cpu_read | cpu_write;
    assign w_dbg_req = dbg_read | dbg_write;
    assign grant_dbg = r_grant_dbg;

    // IDLE arbitration: debug wins when starved or alone
    always_comb begin
        w_dbg_win = 1'b0;
        w_cpu_win = 1'b0;
        if (reset && r_state == IDLE) begin
            w_dbg_win = w_dbg_req &&
                        (r_cnt == MAX_C || !w_cpu_req);
            w_cpu_win = w_cpu_req && !w_dbg_win;
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // Next state and memory/master outputs
    always_comb begin
        w_next          = r_state;
        mem_address     = '0;
        mem_read        = 1'b0;
        mem_write       = 1'b0;
        mem_writedata   = '0;
        cpu_readdata    = '0;
        dbg_readdata    = '0;
        cpu_waitrequest = 1'b1;
        dbg_waitrequest = 1'b1;
        if (reset) begin
            case (r_state)
                IDLE: begin
                    if (w_dbg_win) begin
                        mem_address = dbg_address;
                        if (dbg_write) begin
                            mem_write       = 1'b1;
                            mem_writedata   = dbg_writedata;
                            dbg_waitrequest = 1'b0;
                        end else begin
                            mem_read = 1'b1;
                            w_next   = DBG_RD;
                        end
                    end else if (w_cpu_win) begin
                        mem_address = cpu_address;
                        if (cpu_write) begin
                            mem_write       = 1'b1;
                            mem_writedata   = cpu_writedata;
                            cpu_waitrequest = 1'b0;
                        end else begin
                            mem_read = 1'b1;
                            w_next   = CPU_RD;
                        end
                    end
                end
                CPU_RD: begin
                    cpu_readdata    = mem_readdata;
                    cpu_waitrequest = 1'b0;
                    w_next          = IDLE;
                end
                DBG_RD: begin
                    dbg_readdata    = mem_readdata;
                    dbg_waitrequest = 1'b0;
                    w_next          = IDLE;
                end
                default: w_next = IDLE;
            endcase
        end
    end

    // Starvation counter: counts ungranted debug cycles
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (w_dbg_win) begin
            r_cnt <= '0;
        end else if (w_dbg_req && r_state != DBG_RD &&
                     r_cnt != MAX_C) begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

    // Grant owner updates when an access finishes
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_grant_dbg <= 1'b0;
        end else if (r_state == CPU_RD) begin
            r_grant_dbg <= 1'b0;
        end else if (r_state == DBG_RD) begin
            r_grant_dbg <= 1'b1;
        end else if (w_dbg_win && dbg_write) begin
            r_grant_dbg <= 1'b1;
        end else if (w_cpu_win && cpu_write) begin
            r_grant_dbg <= 1'b0;
        end
    end

`ifdef ARB_PERF_EN
    logic [31:0] r_stall;
    logic        w_stall;

    assign w_stall = w_cpu_req && cpu_waitrequest &&
                     (w_dbg_win || r_state == DBG_RD);
    assign cpu_stall_cycles = r_stall;

    // Saturating count of CPU cycles lost to debug
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stall <= '0;
        end else if (w_stall && r_stall != 32'hFFFF_FFFF) begin
            r_stall <= r_stall + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mips_data_mem_arbiter.sv
// Directed bench for mips_data_mem_arbiter with a one-cycle
// latency memory model on the memory side.
module tb_mips_data_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] cpu_address = '0;
    logic        cpu_read = 1'b0;
    logic        cpu_write = 1'b0;
    logic [31:0] cpu_writedata = '0;
    logic [31:0] cpu_readdata;
    logic        cpu_waitrequest;
    logic [31:0] dbg_address = '0;
    logic        dbg_read = 1'b0;
    logic        dbg_write = 1'b0;
    logic [31:0] dbg_writedata = '0;
    logic [31:0] dbg_readdata;
    logic        dbg_waitrequest;
    logic [31:0] mem_address;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_writedata;
    logic [31:0] mem_readdata = '0;
    logic        grant_dbg;
`ifdef ARB_PERF_EN
    logic [31:0] cpu_stall_cycles;
`endif

    int n_run = 0;
    int n_fail = 0;

    logic [31:0] tb_mem [256];

    mips_data_mem_arbiter dut (
        .clk             (clk),
        .reset           (reset),
        .cpu_address     (cpu_address),
        .cpu_read        (cpu_read),
        .cpu_write       (cpu_write),
        .cpu_writedata   (cpu_writedata),
        .cpu_readdata    (cpu_readdata),
        .cpu_waitrequest (cpu_waitrequest),
        .dbg_address     (dbg_address),
        .dbg_read        (dbg_read),
        .dbg_write       (dbg_write),
        .dbg_writedata   (dbg_writedata),
        .dbg_readdata    (dbg_readdata),
        .dbg_waitrequest (dbg_waitrequest),
        .mem_address     (mem_address),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_writedata   (mem_writedata),
        .mem_readdata    (mem_readdata),
        .grant_dbg       (grant_dbg)
`ifdef ARB_PERF_EN
        ,
        .cpu_stall_cycles(cpu_stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    // Memory model: write on edge, read data valid next cycle
    always @(posedge clk) begin
        if (mem_write)
            tb_mem[mem_address[7:0]] <= mem_writedata;
        mem_readdata <= mem_read ? tb_mem[mem_address[7:0]] : 32'h0;
    end

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    int d1, d2, ncpu, nbad;
    logic [31:0] rd1, rd2;

    initial begin
        for (int i = 0; i < 256; i++) tb_mem[i] = '0;

        // reset state
        cpu_read = 1'b1;
        #1;
        check("rst_mrd", {31'b0, mem_read}, 0);
        check("rst_cwait", {31'b0, cpu_waitrequest}, 1);
        check("rst_dwait", {31'b0, dbg_waitrequest}, 1);
        check("rst_gnt", {31'b0, grant_dbg}, 0);
`ifdef ARB_PERF_EN
        check("rst_stall", cpu_stall_cycles, 0);
`endif
        cpu_read = 1'b0;
        @(negedge clk);
        reset = 1'b1;

        // CPU write 0x10 <= DEADBEEF
        @(negedge clk);
        cpu_address = 32'h10;
        cpu_writedata = 32'hDEADBEEF;
        cpu_write = 1'b1;
        #1;
        check("cw_wait", {31'b0, cpu_waitrequest}, 0);
        check("cw_mwr", {31'b0, mem_write}, 1);
        check("cw_addr", mem_address, 32'h10);
        check("cw_data", mem_writedata, 32'hDEADBEEF);
        @(negedge clk);
        cpu_write = 1'b0;
        #1;
        check("cw_mwr0", {31'b0, mem_write}, 0);

        // CPU read 0x10
        cpu_read = 1'b1;
        #1;
        check("cr_wait1", {31'b0, cpu_waitrequest}, 1);
        check("cr_mrd", {31'b0, mem_read}, 1);
        @(negedge clk);
        #1;
        check("cr_wait0", {31'b0, cpu_waitrequest}, 0);
        check("cr_data", cpu_readdata, 32'hDEADBEEF);
        check("cr_mrd0", {31'b0, mem_read}, 0);
        check("cr_dbgrd", dbg_readdata, 0);
        check("cr_dbgw", {31'b0, dbg_waitrequest}, 1);
        @(negedge clk);
        cpu_read = 1'b0;

        // Debug write 0x20 <= 12345678
        dbg_address = 32'h20;
        dbg_writedata = 32'h12345678;
        dbg_write = 1'b1;
        #1;
        check("dw_wait", {31'b0, dbg_waitrequest}, 0);
        check("dw_addr", mem_address, 32'h20);
        check("dw_mwr", {31'b0, mem_write}, 1);
        @(negedge clk);
        dbg_write = 1'b0;
        #1;
        check("dw_gnt", {31'b0, grant_dbg}, 1);
        cpu_address = 32'h20;
        cpu_read = 1'b1;
        @(negedge clk);
        #1;
        check("cr20_data", cpu_readdata, 32'h12345678);
        @(negedge clk);
        cpu_read = 1'b0;
        #1;
        check("cr20_gnt", {31'b0, grant_dbg}, 0);

        // Starvation: CPU back-to-back reads, debug reads 0x10 twice
        cpu_address = 32'h10;
        dbg_address = 32'h10;
        d1 = 999; d2 = 999; ncpu = 0; nbad = 0;
        rd1 = '0; rd2 = '0;
        for (int n = 0; n < 25; n++) begin
            @(negedge clk);
            cpu_read = 1'b1;
            if (n == 0 || n == 10) dbg_read = 1'b1;
            #1;
            if (!cpu_waitrequest) begin
                ncpu++;
                if (cpu_readdata !== 32'hDEADBEEF) nbad++;
            end
            if (dbg_read && !dbg_waitrequest) begin
                if (n < 10) begin d1 = n; rd1 = dbg_readdata; end
                else        begin d2 = n; rd2 = dbg_readdata; end
                dbg_read = 1'b0;
            end
        end
        check("starv_d1", d1, 9);
        check("starv_rd1", rd1, 32'hDEADBEEF);
        check("starv_d2", d2, 19);
        check("starv_rd2", rd2, 32'hDEADBEEF);
        check("starv_ncpu", ncpu, 10);
        check("starv_bad", nbad, 0);
`ifdef ARB_PERF_EN
        check("perf_stall", cpu_stall_cycles, 4);
`endif
        @(negedge clk);
        cpu_read = 1'b0;
        #1;
        check("starv_gnt", {31'b0, grant_dbg}, 0);

        // Simultaneous writes to 0x30: CPU first, debug next
        @(negedge clk);
        cpu_address = 32'h30; cpu_writedata = 32'd1;
        dbg_address = 32'h30; dbg_writedata = 32'd2;
        cpu_write = 1'b1; dbg_write = 1'b1;
        #1;
        check("ww_cwait", {31'b0, cpu_waitrequest}, 0);
        check("ww_dwait1", {31'b0, dbg_waitrequest}, 1);
        check("ww_data1", mem_writedata, 1);
        @(negedge clk);
        cpu_write = 1'b0;
        #1;
        check("ww_dwait0", {31'b0, dbg_waitrequest}, 0);
        check("ww_data2", mem_writedata, 2);
        @(negedge clk);
        dbg_write = 1'b0;
        #1;
        check("ww_mem", tb_mem[8'h30], 2);
        check("ww_gnt", {31'b0, grant_dbg}, 1);

        // Read+write together counts as a write
        cpu_address = 32'h40; cpu_writedata = 32'h55;
        cpu_read = 1'b1; cpu_write = 1'b1;
        #1;
        check("rw_mwr", {31'b0, mem_write}, 1);
        check("rw_mrd", {31'b0, mem_read}, 0);
        check("rw_wait", {31'b0, cpu_waitrequest}, 0);
        @(negedge clk);
        cpu_write = 1'b0;
        cpu_address = 32'h10;

        // Reset during CPU_RD aborts the read
        #1;
        check("ra_mrd", {31'b0, mem_read}, 1);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("ra_mrd0", {31'b0, mem_read}, 0);
        check("ra_cwait", {31'b0, cpu_waitrequest}, 1);
        check("ra_dwait", {31'b0, dbg_waitrequest}, 1);
        check("ra_crd", cpu_readdata, 0);
        check("ra_gnt", {31'b0, grant_dbg}, 0);
`ifdef ARB_PERF_EN
        check("ra_stall", cpu_stall_cycles, 0);
`endif
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("rr_wait1", {31'b0, cpu_waitrequest}, 1);
        check("rr_mrd", {31'b0, mem_read}, 1);
        @(negedge clk);
        #1;
        check("rr_wait0", {31'b0, cpu_waitrequest}, 0);
        check("rr_data", cpu_readdata, 32'hDEADBEEF);
        @(negedge clk);
        cpu_read = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
